// File: rtl/cti8_pkg.sv
// Purpose: shared types and constants for the interrupt entry sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cti8_pkg;

   // Encodings are visible on the debug state port, so they are pinned explicitly.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_PUSH_H = 4'd1,
      ST_PUSH_L = 4'd2,
      ST_PUSH_F = 4'd3,
      ST_VEC_LO = 4'd4,
      ST_VEC_HI = 4'd5,
      ST_LOAD   = 4'd6,
      ST_RV_LO  = 4'd7,
      ST_RV_HI  = 4'd8
   } seq_state_t;

   // Vector low-byte addresses; the high byte always sits at +1.
   localparam logic [15:0] VEC_NMI_ADDR = 16'hFFFA;
   localparam logic [15:0] VEC_RST_ADDR = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ_ADDR = 16'hFFFE;

   // High address byte for stack accesses.
   localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;

endpackage

// File: rtl/interrupt_sequencer.sv
// Purpose: runs the interrupt/reset entry micro-sequence (push PCH, PCL, flags; fetch vector; load PC).
// Latency: entry to pc_load is 6 enabled cycles; reset release to pc_load is 3 enabled cycles.
// Backpressure: clk_en stalls every register; pulses are qualified by clk_en so a stall never repeats them.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (lands in the reset-vector fetch)
//   clk_en              step enable
//   int_req, nmi_req    interrupt request and vector select from the interrupt latch logic
//   instr_done          CPU is at an instruction boundary this enabled cycle
//   pc, flags, sp       CPU context to push; sp points at the next free stack byte
//   data_in             memory read data for bus_addr, same cycle
//   intHold             sequencer owns the bus, core stalls; its rising edge clears upstream latches
//   bus_addr/wdata/we   memory bus while intHold
//   sp_dec              core decrements sp (one per push)
//   set_iflag, pc_load  core sets I flag / loads pc_new
//   pc_new              vector value assembled from the two reads
//   state               current state encoding
module interrupt_sequencer
   import cti8_pkg::*;
#(
   parameter logic [15:0] VEC_NMI    = VEC_NMI_ADDR,
   parameter logic [15:0] VEC_RST    = VEC_RST_ADDR,
   parameter logic [15:0] VEC_IRQ    = VEC_IRQ_ADDR,
   parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        int_req,
   input  logic        nmi_req,
   input  logic        instr_done,
   input  logic [15:0] pc,
   input  logic [7:0]  flags,
   input  logic [7:0]  sp,
   input  logic [7:0]  data_in,
   output logic        intHold,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_we,
   output logic        sp_dec,
   output logic        set_iflag,
   output logic        pc_load,
   output logic [15:0] pc_new,
   output logic [3:0]  state
);

   seq_state_t  cur_state, nxt_state;
   logic        nmi_sel_q, nmi_sel_d;
   logic        push, load, cap_lo, cap_hi;
   logic [15:0] vec;

   // Vector choice is frozen at entry; a late NMI stays pending upstream.
   assign vec   = nmi_sel_q ? VEC_NMI : VEC_IRQ;
   assign state = cur_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= ST_RV_LO;
         nmi_sel_q <= 1'b0;
         pc_new    <= 16'h0000;
      end else if (clk_en) begin
         cur_state <= nxt_state;
         nmi_sel_q <= nmi_sel_d;
         if (cap_lo) pc_new[7:0]  <= data_in;
         if (cap_hi) pc_new[15:8] <= data_in;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      nmi_sel_d = nmi_sel_q;
      intHold   = 1'b1;
      bus_addr  = 16'h0000;
      bus_wdata = 8'h00;
      push      = 1'b0;
      load      = 1'b0;
      cap_lo    = 1'b0;
      cap_hi    = 1'b0;

      case (cur_state)
         ST_IDLE: begin
            intHold = 1'b0;
            if (int_req && instr_done) begin
               nmi_sel_d = nmi_req;
               nxt_state = ST_PUSH_H;
            end
         end
         // sp is taken live each push: the core applies sp_dec before the next enabled edge.
         ST_PUSH_H: begin
            bus_addr  = {STACK_PAGE, sp};
            bus_wdata = pc[15:8];
            push      = 1'b1;
            nxt_state = ST_PUSH_L;
         end
         ST_PUSH_L: begin
            bus_addr  = {STACK_PAGE, sp};
            bus_wdata = pc[7:0];
            push      = 1'b1;
            nxt_state = ST_PUSH_F;
         end
         ST_PUSH_F: begin
            bus_addr  = {STACK_PAGE, sp};
            bus_wdata = flags;
            push      = 1'b1;
            nxt_state = ST_VEC_LO;
         end
         ST_VEC_LO: begin
            bus_addr  = vec;
            cap_lo    = 1'b1;
            nxt_state = ST_VEC_HI;
         end
         ST_VEC_HI: begin
            bus_addr  = vec + 16'd1;
            cap_hi    = 1'b1;
            nxt_state = ST_LOAD;
         end
         // Shared tail for the interrupt and reset paths.
         ST_LOAD: begin
            load      = 1'b1;
            nxt_state = ST_IDLE;
         end
         ST_RV_LO: begin
            bus_addr  = VEC_RST;
            cap_lo    = 1'b1;
            nxt_state = ST_RV_HI;
         end
         ST_RV_HI: begin
            bus_addr  = VEC_RST + 16'd1;
            cap_hi    = 1'b1;
            nxt_state = ST_LOAD;
         end
         default: begin
            intHold   = 1'b0;
            nxt_state = ST_IDLE;
         end
      endcase

      bus_we    = push & clk_en;
      sp_dec    = push & clk_en;
      pc_load   = load & clk_en;
      set_iflag = load & clk_en;
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst, clk_en, int_req, nmi_req, instr_done;
   logic [15:0] pc;
   logic [7:0]  flags, sp, data_in;
   logic        intHold, bus_we, sp_dec, set_iflag, pc_load;
   logic [15:0] bus_addr, pc_new;
   logic [7:0]  bus_wdata;
   logic [3:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   // Core model state
   logic        sp_ld;
   logic [7:0]  sp_init;

   // Bus/pulse log (filled on the falling edge)
   logic [15:0] wr_a[$];
   logic [7:0]  wr_d[$];
   logic [15:0] rd_a[$];
   logic [15:0] ld_v[$];
   int          ld_c[$];
   int          ld_hold[$];
   int          en_cyc, hold_en, hold_raw, iflag_cnt, bad_pulse;

   always #5 clk = ~clk;

   interrupt_sequencer dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .int_req(int_req), .nmi_req(nmi_req),
      .instr_done(instr_done), .pc(pc), .flags(flags), .sp(sp), .data_in(data_in),
      .intHold(intHold), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
      .sp_dec(sp_dec), .set_iflag(set_iflag), .pc_load(pc_load), .pc_new(pc_new), .state(state)
   );

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      case (a)
         16'hFFFA: return 8'h78;
         16'hFFFB: return 8'h56;
         16'hFFFC: return 8'h34;
         16'hFFFD: return 8'h12;
         16'hFFFE: return 8'hEF;
         16'hFFFF: return 8'hBE;
         default:  return a[7:0] ^ 8'hA5;
      endcase
   endfunction

   assign data_in = mem_rd(bus_addr);

   // Core: owns sp, decrements on an enabled sp_dec.
   always @(posedge clk) begin
      if (sp_ld) sp <= sp_init;
      else if (clk_en && sp_dec) sp <= sp - 8'd1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (clk_en) begin
            en_cyc++;
            if (intHold) hold_en++;
            if (bus_we) begin
               wr_a.push_back(bus_addr);
               wr_d.push_back(bus_wdata);
            end else if (intHold && !pc_load) begin
               rd_a.push_back(bus_addr);
            end
            if (pc_load) begin
               ld_v.push_back(pc_new);
               ld_c.push_back(en_cyc);
               ld_hold.push_back(hold_en);
            end
            if (set_iflag) iflag_cnt++;
         end else if (bus_we || sp_dec || pc_load || set_iflag) begin
            bad_pulse++;
         end
         if (intHold) hold_raw++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_a.delete(); wr_d.delete(); rd_a.delete(); ld_v.delete(); ld_c.delete(); ld_hold.delete();
      en_cyc = 0; hold_en = 0; hold_raw = 0; iflag_cnt = 0; bad_pulse = 0;
   endtask

   task automatic set_core(input logic [15:0] p, input logic [7:0] f, input logic [7:0] s);
      pc = p; flags = f; sp_init = s; sp_ld = 1'b1;
      cyc();
      sp_ld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clk_en = 1'b1; int_req = 1'b0; nmi_req = 1'b0; instr_done = 1'b0;
      pc = 16'h0; flags = 8'h0; sp_init = 8'hFF; sp_ld = 1'b1;
      clear_log();
      #2;
      n_cmp++; if (state !== 4'd7) begin n_bad++; $display("FAIL rst_state: got %0d expected 7", state); end
      n_cmp++; if (intHold !== 1'b1) begin n_bad++; $display("FAIL rst_hold: got %b expected 1", intHold); end
      n_cmp++; if (bus_addr !== 16'hFFFC) begin n_bad++; $display("FAIL rst_addr: got %h expected fffc", bus_addr); end
      n_cmp++; if ({bus_we, sp_dec, set_iflag, pc_load} !== 4'b0000) begin n_bad++; $display("FAIL rst_pulses: got %b expected 0000", {bus_we, sp_dec, set_iflag, pc_load}); end
      n_cmp++; if (pc_new !== 16'h0000) begin n_bad++; $display("FAIL rst_pcnew: got %h expected 0000", pc_new); end
      cyc(); cyc();
      sp_ld = 1'b0;
      rst = 1'b0;
      clear_log();
      cyc(); cyc();
      n_cmp++; if ({pc_load, set_iflag} !== 2'b11) begin n_bad++; $display("FAIL rv_load: got %b expected 11", {pc_load, set_iflag}); end
      n_cmp++; if (pc_new !== 16'h1234) begin n_bad++; $display("FAIL rv_pcnew: got %h expected 1234", pc_new); end
      cyc();
      n_cmp++; if ({state, intHold} !== 5'b0000_0) begin n_bad++; $display("FAIL rv_idle: got state %0d hold %b expected 0/0", state, intHold); end
      n_cmp++; if (wr_a.size() != 0 || ld_hold.size() != 1 || ld_hold[0] != 3) begin n_bad++; $display("FAIL rv_latency: got writes %0d loads %0d hold %0d expected 0/1/3", wr_a.size(), ld_hold.size(), (ld_hold.size() > 0) ? ld_hold[0] : -1); end
   endtask

   task automatic check_seq(input string nm, input logic [15:0] a0, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2, input logic [15:0] v,
                            input logic [15:0] pcn);
      logic [15:0] ea[3];
      logic [7:0]  ed[3];
      ea[0] = a0; ea[1] = a0 - 16'd1; ea[2] = a0 - 16'd2;
      ed[0] = d0; ed[1] = d1; ed[2] = d2;
      n_cmp++; if (wr_a.size() != 3) begin n_bad++; $display("FAIL %s_nwr: got %0d expected 3", nm, wr_a.size()); end
      for (int i = 0; i < 3 && i < wr_a.size(); i++) begin
         n_cmp++; if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i]) begin n_bad++; $display("FAIL %s_wr%0d: got %h=%h expected %h=%h", nm, i, wr_a[i], wr_d[i], ea[i], ed[i]); end
      end
      n_cmp++; if (rd_a.size() != 2 || rd_a[0] !== v || rd_a[1] !== v + 16'd1) begin n_bad++; $display("FAIL %s_rd: got %0d reads first %h expected 2 reads at %h", nm, rd_a.size(), (rd_a.size() > 0) ? rd_a[0] : 16'h0, v); end
      n_cmp++; if (ld_v.size() != 1 || ld_v[0] !== pcn || iflag_cnt != 1) begin n_bad++; $display("FAIL %s_load: got %0d loads val %h iflag %0d expected 1 load %h iflag 1", nm, ld_v.size(), (ld_v.size() > 0) ? ld_v[0] : 16'h0, iflag_cnt, pcn); end
      n_cmp++; if (hold_en != 6 || ld_hold.size() != 1 || ld_hold[0] != 6) begin n_bad++; $display("FAIL %s_hold: got %0d enabled hold cycles expected 6 with load in 6th", nm, hold_en); end
      n_cmp++; if (sp !== a0[7:0] - 8'd3) begin n_bad++; $display("FAIL %s_sp: got %h expected %h", nm, sp, a0[7:0] - 8'd3); end
   endtask

   task automatic run_to_idle(input string nm, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         cyc();
         if (state == 4'd0) done = 1'b1;
      end
      n_cmp++; if (!done) begin n_bad++; $display("FAIL %s_timeout: got no return to idle expected within %0d cycles", nm, budget); end
   endtask

   task automatic test_irq();
      set_core(16'hABCD, 8'h5A, 8'hFF);
      nmi_req = 1'b0; int_req = 1'b1; instr_done = 1'b1;
      clear_log();
      cyc();
      n_cmp++; if ({state, bus_addr, bus_wdata, bus_we, sp_dec, intHold} !== {4'd1, 16'h01FF, 8'hAB, 3'b111}) begin n_bad++; $display("FAIL irq_pushh: got st %0d %h=%h we%b dec%b hold%b expected 1 01ff=ab 111", state, bus_addr, bus_wdata, bus_we, sp_dec, intHold); end
      int_req = 1'b0; instr_done = 1'b0;
      run_to_idle("irq", 20);
      check_seq("irq", 16'h01FF, 8'hAB, 8'hCD, 8'h5A, 16'hFFFE, 16'hBEEF);
   endtask

   task automatic test_nmi();
      set_core(16'h1357, 8'hC3, 8'h80);
      nmi_req = 1'b1; int_req = 1'b1; instr_done = 1'b1;
      clear_log();
      cyc();
      int_req = 1'b0; instr_done = 1'b0; nmi_req = 1'b0;
      run_to_idle("nmi", 20);
      check_seq("nmi", 16'h0180, 8'h13, 8'h57, 8'hC3, 16'hFFFA, 16'h5678);
   endtask

   task automatic test_nmi_mid_irq();
      bit done = 1'b0;
      set_core(16'h2468, 8'h11, 8'hFF);
      nmi_req = 1'b0; int_req = 1'b1; instr_done = 1'b1;
      clear_log();
      cyc();
      nmi_req = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         cyc();
         if (ld_v.size() >= 2) done = 1'b1;
      end
      int_req = 1'b0; instr_done = 1'b0; nmi_req = 1'b0;
      n_cmp++; if (!done) begin n_bad++; $display("FAIL mid_timeout: got %0d loads expected 2", ld_v.size()); end
      n_cmp++; if (ld_v.size() != 2 || ld_v[0] !== 16'hBEEF || ld_v[1] !== 16'h5678) begin n_bad++; $display("FAIL mid_vectors: got %h,%h expected beef,5678", (ld_v.size() > 0) ? ld_v[0] : 16'h0, (ld_v.size() > 1) ? ld_v[1] : 16'h0); end
      n_cmp++; if (ld_c.size() != 2 || ld_c[1] - ld_c[0] != 7) begin n_bad++; $display("FAIL mid_reentry: got gap %0d expected 7", (ld_c.size() > 1) ? ld_c[1] - ld_c[0] : -1); end
      n_cmp++; if (rd_a.size() != 4 || rd_a[2] !== 16'hFFFA || rd_a[3] !== 16'hFFFB) begin n_bad++; $display("FAIL mid_reads: got %0d reads expected 4 ending fffa,fffb", rd_a.size()); end
      n_cmp++; if (wr_a.size() != 6 || wr_a[3] !== 16'h01FC || wr_d[3] !== 8'h24 || wr_d[5] !== 8'h11) begin n_bad++; $display("FAIL mid_pushes: got %0d writes expected 6 with 01fc=24 and flags 11", wr_a.size()); end
      cyc();
   endtask

   task automatic test_clk_en_stretch();
      bit done = 1'b0;
      set_core(16'hABCD, 8'h5A, 8'hFF);
      nmi_req = 1'b0; int_req = 1'b1; instr_done = 1'b1;
      clear_log();
      for (int i = 0; i < 60 && !done; i++) begin
         clk_en = (i % 3 == 0);
         cyc();
         if (i == 0) begin int_req = 1'b0; instr_done = 1'b0; end
         if (i > 0 && state == 4'd0) done = 1'b1;
      end
      clk_en = 1'b1;
      n_cmp++; if (!done) begin n_bad++; $display("FAIL stretch_timeout: got no idle expected within 60 cycles"); end
      check_seq("stretch", 16'h01FF, 8'hAB, 8'hCD, 8'h5A, 16'hFFFE, 16'hBEEF);
      n_cmp++; if (hold_raw != 18) begin n_bad++; $display("FAIL stretch_raw: got %0d hold cycles expected 18", hold_raw); end
      n_cmp++; if (bad_pulse != 0) begin n_bad++; $display("FAIL stretch_pulse: got %0d unqualified pulses expected 0", bad_pulse); end
   endtask

   task automatic test_rst_mid();
      set_core(16'hABCD, 8'h5A, 8'hFF);
      nmi_req = 1'b0; int_req = 1'b1; instr_done = 1'b1;
      clear_log();
      cyc();
      int_req = 1'b0; instr_done = 1'b0;
      cyc();
      n_cmp++; if (state !== 4'd2) begin n_bad++; $display("FAIL rmid_pushl: got %0d expected 2", state); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({state, bus_we, sp_dec, intHold, bus_addr} !== {4'd7, 3'b001, 16'hFFFC}) begin n_bad++; $display("FAIL rmid_abort: got st %0d we%b dec%b hold%b %h expected 7 001 fffc", state, bus_we, sp_dec, intHold, bus_addr); end
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      n_cmp++; if (pc_load !== 1'b1 || pc_new !== 16'h1234) begin n_bad++; $display("FAIL rmid_load: got load %b pc %h expected 1 1234", pc_load, pc_new); end
      cyc();
      n_cmp++; if (state !== 4'd0 || wr_a.size() != 1 || wr_a[0] !== 16'h01FF || sp !== 8'hFE) begin n_bad++; $display("FAIL rmid_partial: got st %0d writes %0d sp %h expected 0 1 fe", state, wr_a.size(), sp); end
      n_cmp++; if (rd_a.size() != 2 || rd_a[0] !== 16'hFFFC || rd_a[1] !== 16'hFFFD) begin n_bad++; $display("FAIL rmid_reads: got %0d reads expected fffc,fffd", rd_a.size()); end
   endtask

   task automatic test_wait_no_boundary();
      int_req = 1'b1; instr_done = 1'b0; nmi_req = 1'b1;
      clear_log();
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_cmp++; if ({state, intHold, bus_we, bus_addr} !== 22'd0) begin n_bad++; $display("FAIL wait_c%0d: got st %0d hold %b we %b %h expected idle quiet", i, state, intHold, bus_we, bus_addr); end
      end
      int_req = 1'b0; nmi_req = 1'b0;
      n_cmp++; if (wr_a.size() != 0 || ld_v.size() != 0) begin n_bad++; $display("FAIL wait_bus: got %0d writes %0d loads expected 0", wr_a.size(), ld_v.size()); end
   endtask

   initial begin
      test_reset();
      test_irq();
      test_nmi();
      test_nmi_mid_irq();
      test_clk_en_stretch();
      test_rst_mid();
      test_wait_no_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
